hazard_unit: RTL and testbench

//  Consumer-side control for the ID/EX pipeline register: observes the decode operands and the
//  EX-stage fields leaving ID/EX, and drives stall/flush back into IF/ID/EX plus forwarding selects.

---
 rtl/hazard_pkg.sv | 44 ++++
 rtl/hazard_stage_track.sv | 25 ++
 rtl/hazard_unit.sv | 121 ++++++++++++
 tb/tb_hazard_unit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, constants and helpers for the hazard unit
// Purpose: forwarding-select and branch-FSM enums, the per-stage destination
// record kept in the shadow pipeline, and the RAW / forwarding match helpers.
// Ports: none (package).
package hazard_pkg;

    localparam int REG_AW = 4;
    localparam logic [REG_AW-1:0] PC_REG = 4'd15;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        BR_FLUSH = 1'b1
    } br_state_t;

    typedef struct packed {
        logic              rf_we;
        logic              load;
        logic [REG_AW-1:0] a3;
    } stage_info_t;

    // Decode operand depends on this stage's result; the PC is never tracked.
    function automatic logic raw_hit(input stage_info_t s,
                                     input logic [REG_AW-1:0] a1,
                                     input logic [REG_AW-1:0] a2);
        return s.rf_we && (s.a3 != PC_REG) && ((s.a3 == a1) || (s.a3 == a2));
    endfunction

    // Youngest producer wins: MEM is checked before WB.
    function automatic fwd_sel_t fwd_pick(input stage_info_t m,
                                          input stage_info_t w,
                                          input logic [REG_AW-1:0] a);
        if (a == PC_REG)                 return FWD_RF;
        else if (m.rf_we && m.a3 == a)   return FWD_MEM;
        else if (w.rf_we && w.a3 == a)   return FWD_WB;
        else                             return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_stage_track.sv
// rtl/hazard_stage_track.sv - two-deep shadow of EX destination info (E->M->W)
// Purpose: mirrors what the MEM and WB pipeline registers hold so the hazard
// unit needs no taps on them. Bubbles carry rf_we=0 and shift like any entry.
// Ports: clk, rst (async, active high); e_info in; m_info, w_info out.
module hazard_stage_track
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  stage_info_t e_info,
    output stage_info_t m_info,
    output stage_info_t w_info
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_info <= '0;
            w_info <= '0;
        end else begin
            m_info <= e_info;
            w_info <= m_info;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - stall/flush/forwarding control around the ID/EX register
// Purpose: load-use (or full RAW) stalls, taken-branch flush sequencing and
// operand forwarding selects, all combinational from inputs and local state.
// Build option: HAZARD_FWD_EN enables forwarding; without it every RAW stalls
// until the writer has left WB and both forwarding selects stay at RF.
// Ports: CLK, RST (async, active high); A1_D, A2_D decode sources;
// A1_E, A2_E, RF_WE_E, A3_E, WBSelect_E, BranchTaken_E from ID/EX;
// StallF, StallD, FlushD, FlushE, FwdA_E, FwdB_E outputs.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int RA           = 4,
    parameter int BR_FLUSH_CYC = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [RA-1:0] A1_D,
    input  logic [RA-1:0] A2_D,
    input  logic [RA-1:0] A1_E,
    input  logic [RA-1:0] A2_E,
    input  logic          RF_WE_E,
    input  logic [RA-1:0] A3_E,
    input  logic          WBSelect_E,
    input  logic          BranchTaken_E,
    output logic          StallF,
    output logic          StallD,
    output logic          FlushD,
    output logic          FlushE,
    output logic [1:0]    FwdA_E,
    output logic [1:0]    FwdB_E
);

    localparam int CW = $clog2(BR_FLUSH_CYC + 1);

    stage_info_t e_info;
    stage_info_t m_info;
    stage_info_t w_info;

    br_state_t   state_q;
    br_state_t   state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic        flushing;
    logic        stall;
    fwd_sel_t    fwd_a;
    fwd_sel_t    fwd_b;

    assign e_info = '{rf_we: RF_WE_E, load: WBSelect_E, a3: A3_E};

    hazard_stage_track u_track (
        .clk    (CLK),
        .rst    (RST),
        .e_info (e_info),
        .m_info (m_info),
        .w_info (w_info)
    );

    // The load flag rides along in the shadow but no decision reads it downstream.
    logic unused_load;
    assign unused_load = m_info.load ^ w_info.load;

`ifdef HAZARD_FWD_EN
    assign stall = WBSelect_E && raw_hit(e_info, A1_D, A2_D);
    assign fwd_a = fwd_pick(m_info, w_info, A1_E);
    assign fwd_b = fwd_pick(m_info, w_info, A2_E);
`else
    logic unused_fwd;
    assign unused_fwd = ^{A1_E, A2_E};
    assign stall = raw_hit(e_info, A1_D, A2_D) ||
                   raw_hit(m_info, A1_D, A2_D) ||
                   raw_hit(w_info, A1_D, A2_D);
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        flushing = 1'b0;
        case (state_q)
            RUN: begin
                if (BranchTaken_E) begin
                    flushing = 1'b1;
                    if (BR_FLUSH_CYC > 1) begin
                        state_d = BR_FLUSH;
                        cnt_d   = CW'(BR_FLUSH_CYC - 1);
                    end
                end
            end
            BR_FLUSH: begin
                // EX holds a bubble here, so a taken flag is stale and ignored.
                flushing = 1'b1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // A flushed decode slot is discarded, so stalling it would be pointless.
    assign StallF = !RST && stall && !flushing;
    assign StallD = !RST && stall && !flushing;
    assign FlushD = !RST && flushing;
    assign FlushE = !RST && (flushing || stall);
    assign FwdA_E = RST ? 2'b00 : fwd_a;
    assign FwdB_E = RST ? 2'b00 : fwd_b;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed scoreboard bench for hazard_unit
module tb_hazard_unit;

`ifdef HAZARD_FWD_EN
    localparam bit FWD_BUILD = 1'b1;
`else
    localparam bit FWD_BUILD = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] A1_D, A2_D, A1_E, A2_E, A3_E;
    logic       RF_WE_E, WBSelect_E, BranchTaken_E;
    logic       StallF, StallD, FlushD, FlushE;
    logic [1:0] FwdA_E, FwdB_E;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];

    hazard_unit #(.RA(4), .BR_FLUSH_CYC(2)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .A1_D          (A1_D),
        .A2_D          (A2_D),
        .A1_E          (A1_E),
        .A2_E          (A2_E),
        .RF_WE_E       (RF_WE_E),
        .A3_E          (A3_E),
        .WBSelect_E    (WBSelect_E),
        .BranchTaken_E (BranchTaken_E),
        .StallF        (StallF),
        .StallD        (StallD),
        .FlushD        (FlushD),
        .FlushE        (FlushE),
        .FwdA_E        (FwdA_E),
        .FwdB_E        (FwdB_E)
    );

    always #5 CLK = ~CLK;

    task automatic idle();
        A1_D = 4'd0; A2_D = 4'd0; A1_E = 4'd0; A2_E = 4'd0; A3_E = 4'd0;
        RF_WE_E = 1'b0; WBSelect_E = 1'b0; BranchTaken_E = 1'b0;
    endtask

    // Expected vector: {StallF, StallD, FlushD, FlushE, FwdA_E, FwdB_E}
    task automatic chk(input string tag, input logic [7:0] exp_fwd, input logic [7:0] exp_nofwd);
        logic [7:0] obs;
        logic [7:0] e;
        string      t;
        exp_q.push_back(FWD_BUILD ? exp_fwd : exp_nofwd);
        tag_q.push_back(tag);
        @(negedge CLK);
        obs = {StallF, StallD, FlushD, FlushE, FwdA_E, FwdB_E};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", t, obs, e);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        BranchTaken_E = 1'b1; RF_WE_E = 1'b1; WBSelect_E = 1'b1; A3_E = 4'd4; A1_D = 4'd4;
        chk("reset", 8'b0000_00_00, 8'b0000_00_00);
        RST = 1'b0;

        // forward from MEM; R3 writer walks E, M, W while decode reads R3
        idle(); RF_WE_E = 1'b1; A3_E = 4'd3; A1_D = 4'd3;
        chk("t1_e", 8'b0000_00_00, 8'b1101_00_00);
        idle(); A1_E = 4'd3; A1_D = 4'd3;
        chk("t1_mem", 8'b0000_10_00, 8'b1101_00_00);
        idle(); A1_E = 4'd3; A1_D = 4'd3;
        chk("t1_wb", 8'b0000_01_00, 8'b1101_00_00);
        idle(); A1_E = 4'd3; A1_D = 4'd3;
        chk("t1_clear", 8'b0000_00_00, 8'b0000_00_00);

        // MEM beats WB
        idle(); RF_WE_E = 1'b1; A3_E = 4'd5;
        chk("t2_w0", 8'b0000_00_00, 8'b0000_00_00);
        idle(); RF_WE_E = 1'b1; A3_E = 4'd5;
        chk("t2_w1", 8'b0000_00_00, 8'b0000_00_00);
        idle(); A2_E = 4'd5;
        chk("t2_mem_over_wb", 8'b0000_00_10, 8'b0000_00_00);
        idle(); A2_E = 4'd5;
        chk("t2_wb", 8'b0000_00_01, 8'b0000_00_00);
        idle(); A2_E = 4'd5;
        chk("t2_clear", 8'b0000_00_00, 8'b0000_00_00);

        // load-use
        idle(); WBSelect_E = 1'b1; RF_WE_E = 1'b1; A3_E = 4'd2; A1_D = 4'd2;
        chk("t3_stall", 8'b1101_00_00, 8'b1101_00_00);
        idle(); A1_D = 4'd2;
        chk("t3_bubble", 8'b0000_00_00, 8'b1101_00_00);
        idle(); A1_E = 4'd2;
        chk("t3_fwd_wb", 8'b0000_01_00, 8'b0000_00_00);
        idle();
        chk("t3_clear", 8'b0000_00_00, 8'b0000_00_00);

        // branch beats load-use, lasts two cycles, second taken ignored
        idle(); BranchTaken_E = 1'b1; WBSelect_E = 1'b1; RF_WE_E = 1'b1; A3_E = 4'd7; A1_D = 4'd7;
        chk("t4_br0", 8'b0011_00_00, 8'b0011_00_00);
        idle(); BranchTaken_E = 1'b1; A1_D = 4'd7;
        chk("t4_br1", 8'b0011_00_00, 8'b0011_00_00);
        idle();
        chk("t4_done", 8'b0000_00_00, 8'b0000_00_00);

        // PC register never forwarded nor stalled on
        idle(); RF_WE_E = 1'b1; A3_E = 4'd15; A1_D = 4'd15;
        chk("t5_wr_pc", 8'b0000_00_00, 8'b0000_00_00);
        idle(); A1_E = 4'd15; A2_E = 4'd15; A1_D = 4'd15;
        chk("t5_no_fwd_pc", 8'b0000_00_00, 8'b0000_00_00);
        idle(); WBSelect_E = 1'b1; RF_WE_E = 1'b1; A3_E = 4'd15; A1_D = 4'd15;
        chk("t5_load_pc", 8'b0000_00_00, 8'b0000_00_00);
        idle();
        chk("t5_clear", 8'b0000_00_00, 8'b0000_00_00);

        // reset during a branch flush clears outputs and shadow
        idle(); BranchTaken_E = 1'b1; RF_WE_E = 1'b1; A3_E = 4'd9;
        chk("t6_br", 8'b0011_00_00, 8'b0011_00_00);
        idle(); RST = 1'b1;
        chk("t6_rst", 8'b0000_00_00, 8'b0000_00_00);
        RST = 1'b0;
        idle(); A1_E = 4'd9; A1_D = 4'd9;
        chk("t6_after", 8'b0000_00_00, 8'b0000_00_00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
